// File: rtl/ccff_pkg.sv
// Shared types and limits for the eFPGA configuration-chain memory.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    FULL    = 2'd2
  } ccff_state_t;

  localparam int CCFF_MAX_WIDTH = 256;

endpackage

// File: rtl/ccff_shadow_mem_if.sv
// Bundle of the configuration-chain signals for one ccff_shadow_mem instance.
interface ccff_shadow_mem_if #(
  parameter int WIDTH = 17
);
  import ccff_pkg::*;

  // No valid/ready pair: shift_en and commit are single-cycle strobes sampled on
  // every rising prog_clk edge; the memory never stalls, so there is no back-pressure.
  logic             ccff_head;
  logic             shift_en;
  logic             readback;
  logic             commit;
  logic             ccff_tail;
  logic [WIDTH-1:0] mem_out;
  logic [WIDTH-1:0] mem_outb;
  logic             frame_done;
  logic             cfg_err;
  ccff_state_t      dbg_state;

  modport master (
    output ccff_head, shift_en, readback, commit,
    input  ccff_tail, mem_out, mem_outb, frame_done, cfg_err, dbg_state
  );

  modport slave (
    input  ccff_head, shift_en, readback, commit,
    output ccff_tail, mem_out, mem_outb, frame_done, cfg_err, dbg_state
  );

endinterface

// File: rtl/ccff_frame_ctrl.sv
// Frame bookkeeping: bit counter, IDLE/LOADING/FULL FSM, done and sticky error flags,
// plus the strobes that gate the shadow shift and the shadow-to-active copy.
module ccff_frame_ctrl
  import ccff_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic        prog_clk,
  input  logic        pReset,
  input  logic        i_shift_en,
  input  logic        i_readback,
  input  logic        i_commit,
  output logic        o_shift_ok,
  output logic        o_commit_ok,
  output logic        o_frame_done,
  output logic        o_cfg_err,
  output ccff_state_t o_state
);

  ccff_state_t      r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_frame_done;
  logic             r_cfg_err;

  // Readback while half-loaded would scramble the frame, so that shift is suppressed.
  assign o_shift_ok   = i_shift_en & ~((r_state == LOADING) & i_readback);
  assign o_commit_ok  = i_commit & ~i_shift_en & (r_state == FULL);
  assign o_frame_done = r_frame_done;
  assign o_cfg_err    = r_cfg_err;
  assign o_state      = r_state;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else if (i_shift_en) begin
      if (i_commit) r_cfg_err <= 1'b1;
      case (r_state)
        IDLE: begin
          if (!i_readback) begin
            r_count <= CNT_W'(1);
            if (WIDTH == 1) begin
              r_state      <= FULL;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= LOADING;
            end
          end
        end
        LOADING: begin
          if (i_readback) begin
            r_cfg_err <= 1'b1;
          end else begin
            r_count <= r_count + CNT_W'(1);
            if (r_count == CNT_W'(WIDTH - 1)) begin
              r_state      <= FULL;
              r_frame_done <= 1'b1;
            end
          end
        end
        FULL: begin
          // Overflow: count saturates, the shift itself still happens for the cascade.
          if (!i_readback) r_cfg_err <= 1'b1;
        end
        default: begin
          r_state      <= IDLE;
          r_count      <= '0;
          r_frame_done <= 1'b0;
        end
      endcase
    end else if (i_commit) begin
      if (r_state == FULL) begin
        r_state      <= IDLE;
        r_count      <= '0;
        r_frame_done <= 1'b0;
      end else begin
        r_cfg_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ccff_shadow_mem.sv
// Double-buffered configuration chain: serial shadow register feeding a parallel
// active register that drives the routing/LUT fabric.
module ccff_shadow_mem
  import ccff_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic               prog_clk,
  input logic               pReset,
  ccff_shadow_mem_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > CCFF_MAX_WIDTH) begin : g_bad_width
    $error("ccff_shadow_mem: WIDTH out of range");
  end

  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_active_b;
  logic             w_shift_ok;
  logic             w_commit_ok;
  logic             w_shift_in;
  logic             w_frame_done;
  logic             w_cfg_err;
  ccff_state_t      w_state;

  ccff_frame_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_frame_ctrl (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .i_shift_en   (bus.shift_en),
    .i_readback   (bus.readback),
    .i_commit     (bus.commit),
    .o_shift_ok   (w_shift_ok),
    .o_commit_ok  (w_commit_ok),
    .o_frame_done (w_frame_done),
    .o_cfg_err    (w_cfg_err),
    .o_state      (w_state)
  );

  // Readback recirculates the tail so WIDTH rotations restore the shadow intact.
  assign w_shift_in = bus.readback ? r_shadow[WIDTH-1] : bus.ccff_head;

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_shadow <= '0;
    end else if (w_shift_ok) begin
      for (int i = WIDTH - 1; i > 0; i--) begin
        r_shadow[i] <= r_shadow[i-1];
      end
      r_shadow[0] <= w_shift_in;
    end
  end

  // Complement kept as its own register so mem_outb is a pure register tap.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_active   <= '0;
      r_active_b <= '1;
    end else if (w_commit_ok) begin
      r_active   <= r_shadow;
      r_active_b <= ~r_shadow;
    end
  end

  assign bus.ccff_tail  = r_shadow[WIDTH-1];
  assign bus.mem_out    = r_active;
  assign bus.mem_outb   = r_active_b;
  assign bus.frame_done = w_frame_done;
  assign bus.cfg_err    = w_cfg_err;
  assign bus.dbg_state  = w_state;

endmodule

// File: tb/tb_ccff_shadow_mem.sv
// Bench for ccff_shadow_mem: directed vector table, hand-written corner sequences,
// a two-instance cascade and randomized traffic against a count-based frame model.
module tb_ccff_shadow_mem;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b0;

  always #5 prog_clk = ~prog_clk;

  ccff_shadow_mem_if #(.WIDTH(6)) if6 ();
  ccff_shadow_mem_if #(.WIDTH(2)) if2 ();
  ccff_shadow_mem_if #(.WIDTH(3)) if3 ();

  assign if3.ccff_head = if2.ccff_tail;

  ccff_shadow_mem #(.WIDTH(6)) dut6 (.prog_clk(prog_clk), .pReset(pReset), .bus(if6));
  ccff_shadow_mem #(.WIDTH(2)) dut2 (.prog_clk(prog_clk), .pReset(pReset), .bus(if2));
  ccff_shadow_mem #(.WIDTH(3)) dut3 (.prog_clk(prog_clk), .pReset(pReset), .bus(if3));

  int n_cmp = 0;
  int n_bad = 0;

  // Frame model: state is implied by how many bits of the current frame were loaded.
  logic [5:0] m_shadow;
  logic [5:0] m_active;
  int         m_count;
  bit         m_err;

  typedef struct {
    bit         sh;
    bit         rb;
    bit         cm;
    bit         hd;
    bit         tail;
    logic [5:0] mem;
    bit         done;
    bit         err;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_shadow = '0;
    m_active = '0;
    m_count  = 0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input bit sh, input bit rb, input bit cm, input bit hd);
    bit in_bit;
    if (sh) begin
      if (m_count > 0 && m_count < 6 && rb) begin
        m_err = 1'b1;
      end else begin
        in_bit   = rb ? m_shadow[5] : hd;
        m_shadow = (m_shadow << 1) | 6'(in_bit);
        if (!rb) begin
          if (m_count == 6) m_err = 1'b1;
          else m_count++;
        end
      end
      if (cm) m_err = 1'b1;
    end else if (cm) begin
      if (m_count == 6) begin
        m_active = m_shadow;
        m_count  = 0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".mem_out"},    32'(if6.mem_out),    32'(m_active));
    chk({tag, ".mem_outb"},   32'(if6.mem_outb),   32'(6'(~m_active)));
    chk({tag, ".ccff_tail"},  32'(if6.ccff_tail),  32'(m_shadow[5]));
    chk({tag, ".frame_done"}, 32'(if6.frame_done), 32'(m_count == 6));
    chk({tag, ".cfg_err"},    32'(if6.cfg_err),    32'(m_err));
  endtask

  task automatic idle_inputs();
    if6.shift_en = 1'b0; if6.readback = 1'b0; if6.commit = 1'b0; if6.ccff_head = 1'b0;
    if2.shift_en = 1'b0; if2.readback = 1'b0; if2.commit = 1'b0; if2.ccff_head = 1'b0;
    if3.shift_en = 1'b0; if3.readback = 1'b0; if3.commit = 1'b0;
  endtask

  task automatic step6(input bit sh, input bit rb, input bit cm, input bit hd);
    if6.shift_en  = sh;
    if6.readback  = rb;
    if6.commit    = cm;
    if6.ccff_head = hd;
    @(posedge prog_clk);
    #1;
    model_step(sh, rb, cm, hd);
  endtask

  task automatic step_cascade(input bit sh, input bit cm, input bit hd);
    if2.shift_en  = sh; if2.commit = cm; if2.ccff_head = hd;
    if3.shift_en  = sh; if3.commit = cm;
    @(posedge prog_clk);
    #1;
  endtask

  // Called just after a rising edge; asserts reset away from any edge.
  task automatic do_reset();
    idle_inputs();
    #2 pReset = 1'b0;
    #1;
    model_reset();
    check_model("reset");
    @(negedge prog_clk);
    pReset = 1'b1;
    @(posedge prog_clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_a;
    logic [2:0] exp_b;
    bit         casc_q[$];
    int         n;
    int         op;
    bit         b;

    idle_inputs();
    model_reset();
    repeat (2) @(posedge prog_clk);
    #1;
    pReset = 1'b1;
    @(posedge prog_clk);
    #1;
    do_reset();

    // Load 1,0,1,1,0,0, commit, then read the frame back through six rotations.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'b101100, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101100, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b101100, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b101100, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101100, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'b101100, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'b101100, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step6(tbl[i].sh, tbl[i].rb, tbl[i].cm, tbl[i].hd);
      chk($sformatf("vec%0d.tail", i), 32'(if6.ccff_tail),  32'(tbl[i].tail));
      chk($sformatf("vec%0d.mem", i),  32'(if6.mem_out),    32'(tbl[i].mem));
      chk($sformatf("vec%0d.memb", i), 32'(if6.mem_outb),   32'(6'(~tbl[i].mem)));
      chk($sformatf("vec%0d.done", i), 32'(if6.frame_done), 32'(tbl[i].done));
      chk($sformatf("vec%0d.err", i),  32'(if6.cfg_err),    32'(tbl[i].err));
    end

    // Premature commit after three shifts: active frame must survive, error sticks.
    step6(1'b1, 1'b0, 1'b0, 1'b1);
    step6(1'b1, 1'b0, 1'b0, 1'b1);
    step6(1'b1, 1'b0, 1'b0, 1'b1);
    chk("premature.err_before", 32'(if6.cfg_err), 32'd0);
    step6(1'b0, 1'b0, 1'b1, 1'b0);
    chk("premature.mem", 32'(if6.mem_out), 32'b101100);
    chk("premature.err", 32'(if6.cfg_err), 32'd1);
    step6(1'b0, 1'b0, 1'b0, 1'b0);
    step6(1'b0, 1'b0, 1'b0, 1'b0);
    chk("premature.err_sticky", 32'(if6.cfg_err), 32'd1);

    // Asynchronous reset mid-stream, checked before any clock edge.
    step6(1'b1, 1'b0, 1'b0, 1'b1);
    do_reset();

    // Overflow: seventh shift still moves data, count saturates, error raised.
    step6(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step6(1'b1, 1'b0, 1'b0, 1'b0);
    chk("overflow.tail_first", 32'(if6.ccff_tail),  32'd1);
    chk("overflow.done_pre",   32'(if6.frame_done), 32'd1);
    step6(1'b1, 1'b0, 1'b0, 1'b0);
    chk("overflow.err",        32'(if6.cfg_err),    32'd1);
    chk("overflow.done",       32'(if6.frame_done), 32'd1);
    chk("overflow.tail_next",  32'(if6.ccff_tail),  32'd0);
    chk("overflow.mem",        32'(if6.mem_out),    32'd0);

    // Cascade W=2 -> W=3: five bits, a conflicting commit+shift, then a clean commit.
    do_reset();
    foreach (casc_q[i]) casc_q.delete(i);
    for (int i = 0; i < 5; i++) begin
      b = 1'($urandom_range(0, 1));
      casc_q.push_back(b);
      step_cascade(1'b1, 1'b0, b);
    end
    chk("cascade.a_done", 32'(if2.frame_done), 32'd1);
    chk("cascade.b_done", 32'(if3.frame_done), 32'd1);
    b = 1'($urandom_range(0, 1));
    casc_q.push_back(b);
    step_cascade(1'b1, 1'b1, b);
    chk("cascade.a_err", 32'(if2.cfg_err), 32'd1);
    chk("cascade.b_err", 32'(if3.cfg_err), 32'd1);
    chk("cascade.a_mem0", 32'(if2.mem_out), 32'd0);
    chk("cascade.b_mem0", 32'(if3.mem_out), 32'd0);
    step_cascade(1'b0, 1'b1, 1'b0);
    n = casc_q.size();
    for (int i = 0; i < 2; i++) exp_a[i] = casc_q[n-1-i];
    for (int i = 0; i < 3; i++) exp_b[i] = casc_q[n-3-i];
    chk("cascade.a_mem",  32'(if2.mem_out),    32'(exp_a));
    chk("cascade.a_memb", 32'(if2.mem_outb),   32'(2'(~exp_a)));
    chk("cascade.b_mem",  32'(if3.mem_out),    32'(exp_b));
    chk("cascade.b_memb", 32'(if3.mem_outb),   32'(3'(~exp_b)));
    chk("cascade.a_done", 32'(if2.frame_done), 32'd0);
    chk("cascade.b_done", 32'(if3.frame_done), 32'd0);
    step_cascade(1'b0, 1'b0, 1'b0);

    // Randomized traffic on the WIDTH=6 instance against the frame model.
    do_reset();
    for (int it = 0; it < 600; it++) begin
      op = int'($urandom_range(0, 99));
      b  = 1'($urandom_range(0, 1));
      if (op < 65)      step6(1'b1, 1'b0, 1'b0, b);
      else if (op < 75) step6(1'b1, 1'b1, 1'b0, b);
      else if (op < 88) step6(1'b0, 1'b0, 1'b1, b);
      else if (op < 92) step6(1'b1, 1'b0, 1'b1, b);
      else              step6(1'b0, 1'b0, 1'b0, b);
      check_model($sformatf("rand%0d", it));
      if (m_err && $urandom_range(0, 5) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
